// File: rtl/mem0_stage.sv
// mem0_stage: first memory pipeline stage; latches the EX->MEM0 bus and issues one data request
// per load/store. Define MEM0_ALIGN_CHECK_EN to suppress misaligned requests and flag ale.
module mem0_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [6+3*ADDR_W+RD_W:0]      ex2mem0_bus_i,
    input  logic                          ex2mem0_valid_i,
    output logic                          mem0_allow_in_o,
`ifdef MEM0_ALIGN_CHECK_EN
    output logic [9+2*ADDR_W+RD_W:0]      mem02mem1_bus_o,
`else
    output logic [8+2*ADDR_W+RD_W:0]      mem02mem1_bus_o,
`endif
    output logic                          mem02mem1_valid_o,
    input  logic                          mem1_allow_in_i,
    output logic                          data_req_o,
    output logic                          data_wr_o,
    output logic [1:0]                    data_size_o,
    output logic [ADDR_W-1:0]             data_addr_o,
    output logic [3:0]                    data_wstrb_o,
    output logic [ADDR_W-1:0]             data_wdata_o,
    input  logic                          data_addr_ok_i,
    output logic [RD_W-1:0]               ctl_mem0_dest_o,
    output logic [ADDR_W-1:0]             forward_mem0_data_o,
    output logic [ADDR_W-1:0]             ctl_mem0_pc_o
);

    localparam int unsigned InW    = 7 + 3 * ADDR_W + RD_W;
    localparam int unsigned RdLsb  = ADDR_W + 1;
    localparam int unsigned ExLsb  = RdLsb + RD_W;
    localparam int unsigned StLsb  = ExLsb + ADDR_W;
    localparam int unsigned CtlLsb = StLsb + ADDR_W;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [InW-1:0]   bus_q, bus_d;

    logic [5:0]        in_ctl;
    logic [ADDR_W-1:0] in_exe;
    logic              in_mem_op;
    logic              in_ale;
    logic              accept;
    logic              over;

    logic [5:0]        ctl;
    logic [ADDR_W-1:0] st;
    logic [ADDR_W-1:0] exe;
    logic [RD_W-1:0]   rd;
    logic              rd_we;
    logic [ADDR_W-1:0] pc;
    logic              ale;
    logic              rd_we_out;

`ifdef MEM0_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [5:0] c, input logic [1:0] a);
        logic bad;
        case (c[3:2])
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            default: bad = (a != 2'b00);
        endcase
        return (c[5] | c[4]) & bad;
    endfunction
`endif

    assign in_ctl    = ex2mem0_bus_i[CtlLsb +: 6];
    assign in_exe    = ex2mem0_bus_i[ExLsb +: ADDR_W];
    assign in_mem_op = in_ctl[5] | in_ctl[4];

    assign ctl   = bus_q[CtlLsb +: 6];
    assign st    = bus_q[StLsb +: ADDR_W];
    assign exe   = bus_q[ExLsb +: ADDR_W];
    assign rd    = bus_q[RdLsb +: RD_W];
    assign rd_we = bus_q[ADDR_W];
    assign pc    = bus_q[ADDR_W-1:0];

`ifdef MEM0_ALIGN_CHECK_EN
    assign in_ale = misaligned(in_ctl, in_exe[1:0]);
    assign ale    = misaligned(ctl, exe[1:0]);
`else
    assign in_ale = 1'b0;
    assign ale    = 1'b0;
`endif

    assign rd_we_out       = rd_we & ~ale;
    assign over            = (state_q == StDone);
    assign mem0_allow_in_o = ~valid_q | (over & mem1_allow_in_i);
    assign accept          = ex2mem0_valid_i & mem0_allow_in_o;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        bus_d   = bus_q;
        unique case (state_q)
            StReq: begin
                if (data_addr_ok_i) state_d = StDone;
            end
            StDone: begin
                if (mem1_allow_in_i) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        // A new instruction may enter on the same edge the finished one leaves.
        if (accept) begin
            bus_d   = ex2mem0_bus_i;
            valid_d = 1'b1;
            state_d = (in_mem_op & ~in_ale) ? StReq : StDone;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            bus_q   <= bus_d;
        end
    end

    assign data_req_o        = (state_q == StReq);
    assign mem02mem1_valid_o = over;
    assign data_wr_o         = ctl[4];
    assign data_size_o       = ctl[3:2];
    assign data_addr_o       = exe;

    always_comb begin
        data_wstrb_o = 4'b0000;
        data_wdata_o = st;
        case (ctl[3:2])
            2'b00: begin
                data_wdata_o = {4{st[7:0]}};
                if (ctl[4]) data_wstrb_o = 4'b0001 << exe[1:0];
            end
            2'b01: begin
                data_wdata_o = {2{st[15:0]}};
                if (ctl[4]) data_wstrb_o = 4'b0011 << exe[1:0];
            end
            default: begin
                if (ctl[4]) data_wstrb_o = 4'b1111;
            end
        endcase
    end

`ifdef MEM0_ALIGN_CHECK_EN
    assign mem02mem1_bus_o = {ale, ctl, exe[1:0], exe, rd, rd_we_out, pc};
`else
    assign mem02mem1_bus_o = {ctl, exe[1:0], exe, rd, rd_we_out, pc};
`endif

    assign ctl_mem0_dest_o     = (valid_q & rd_we_out) ? rd : '0;
    assign forward_mem0_data_o = valid_q ? exe : '0;
    assign ctl_mem0_pc_o       = pc;

endmodule

// File: tb/tb_mem0_stage.sv
// Scoreboard bench for mem0_stage: accepted instructions are queued, a monitor checks the
// memory request and MEM1 handoff of the held instruction against a behavioural model.
module tb_mem0_stage;

`ifdef MEM0_ALIGN_CHECK_EN
    localparam int OW = 79;
`else
    localparam int OW = 78;
`endif

    typedef struct packed {
        logic [5:0]  ctl;
        logic [31:0] st;
        logic [31:0] exe;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
    } instr_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [107:0]  ex2mem0_bus_i;
    logic          ex2mem0_valid_i;
    logic          mem0_allow_in_o;
    logic [OW-1:0] mem02mem1_bus_o;
    logic          mem02mem1_valid_o;
    logic          mem1_allow_in_i;
    logic          data_req_o;
    logic          data_wr_o;
    logic [1:0]    data_size_o;
    logic [31:0]   data_addr_o;
    logic [3:0]    data_wstrb_o;
    logic [31:0]   data_wdata_o;
    logic          data_addr_ok_i;
    logic [4:0]    ctl_mem0_dest_o;
    logic [31:0]   forward_mem0_data_o;
    logic [31:0]   ctl_mem0_pc_o;

    mem0_stage dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .ex2mem0_bus_i       (ex2mem0_bus_i),
        .ex2mem0_valid_i     (ex2mem0_valid_i),
        .mem0_allow_in_o     (mem0_allow_in_o),
        .mem02mem1_bus_o     (mem02mem1_bus_o),
        .mem02mem1_valid_o   (mem02mem1_valid_o),
        .mem1_allow_in_i     (mem1_allow_in_i),
        .data_req_o          (data_req_o),
        .data_wr_o           (data_wr_o),
        .data_size_o         (data_size_o),
        .data_addr_o         (data_addr_o),
        .data_wstrb_o        (data_wstrb_o),
        .data_wdata_o        (data_wdata_o),
        .data_addr_ok_i      (data_addr_ok_i),
        .ctl_mem0_dest_o     (ctl_mem0_dest_o),
        .forward_mem0_data_o (forward_mem0_data_o),
        .ctl_mem0_pc_o       (ctl_mem0_pc_o)
    );

    always #5 clk_i = ~clk_i;

    int     vectors = 0;
    int     errs    = 0;
    instr_t inst_q[$];
    logic   front_req_done = 1'b0;
    logic   pending = 1'b0;
    logic [70:0] saved_req;
    logic   acc_pend = 1'b0;
    instr_t acc_ins;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input instr_t i);
        return (i.ctl[3:2] == 2'd0) ? 1 : (i.ctl[3:2] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_mem(input instr_t i);
        return i.ctl[5] || i.ctl[4];
    endfunction

    function automatic logic m_ale(input instr_t i);
`ifdef MEM0_ALIGN_CHECK_EN
        return is_mem(i) && ((i.exe % nbytes(i)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic needs_req(input instr_t i);
        return is_mem(i) && !m_ale(i);
    endfunction

    function automatic logic [3:0] m_wstrb(input instr_t i);
        int n = nbytes(i);
        int a = i.exe % 4;
        int s;
        if (!i.ctl[4]) return 4'h0;
        if (n == 4) return 4'hF;
        s = ((1 << n) - 1) << a;
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input instr_t i);
        int n = nbytes(i);
        if (n == 1) return {24'd0, i.st[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, i.st[15:0]} * 32'h0001_0001;
        return i.st;
    endfunction

    function automatic logic [4:0] m_dest(input instr_t i);
        return (i.we && !m_ale(i)) ? i.rd : 5'd0;
    endfunction

    function automatic logic [OW-1:0] m_bus(input instr_t i);
        logic we_out = i.we && !m_ale(i);
`ifdef MEM0_ALIGN_CHECK_EN
        return {m_ale(i), i.ctl, i.exe[1:0], i.exe, i.rd, we_out, i.pc};
`else
        return {i.ctl, i.exe[1:0], i.exe, i.rd, we_out, i.pc};
`endif
    endfunction

    function automatic instr_t mk(input logic [5:0] c, input logic [31:0] s, input logic [31:0] e,
                                  input logic [4:0] r, input logic w, input logic [31:0] p);
        instr_t i;
        i.ctl = c; i.st = s; i.exe = e; i.rd = r; i.we = w; i.pc = p;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind = $urandom_range(0, 2);
        i.ctl[5:4] = (kind == 1) ? 2'b10 : (kind == 2) ? 2'b01 : 2'b00;
        i.ctl[3:2] = 2'($urandom_range(0, 2));
        i.ctl[1:0] = 2'($urandom_range(0, 3));
        i.st  = $urandom;
        i.exe = $urandom;
        i.rd  = 5'($urandom_range(0, 31));
        i.we  = 1'($urandom_range(0, 1));
        i.pc  = $urandom;
        return i;
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic v, input instr_t ins, input logic m1, input logic ok);
        @(posedge clk_i);
        if (acc_pend) inst_q.push_back(acc_ins);
        acc_pend = 1'b0;
        #1;
        ex2mem0_valid_i = v;
        ex2mem0_bus_i   = ins;
        mem1_allow_in_i = m1;
        data_addr_ok_i  = ok;
        @(negedge clk_i);
        if (v && mem0_allow_in_o) begin
            acc_pend = 1'b1;
            acc_ins  = ins;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        instr_t cur;
        if (rst_i) begin
            inst_q.delete();
            front_req_done = 1'b0;
            pending        = 1'b0;
        end else begin
            check("req_valid_excl", 128'(data_req_o & mem02mem1_valid_o), 128'd0);
            check("req_allow_excl", 128'(data_req_o & mem0_allow_in_o), 128'd0);
            if (inst_q.size() == 0) begin
                check("empty_busy", 128'(data_req_o | mem02mem1_valid_o), 128'd0);
                check("empty_dest", 128'(ctl_mem0_dest_o), 128'd0);
                check("empty_fwd", 128'(forward_mem0_data_o), 128'd0);
                check("empty_allow", 128'(mem0_allow_in_o), 128'd1);
            end else begin
                cur = inst_q[0];
                check("held_busy", 128'(data_req_o | mem02mem1_valid_o), 128'd1);
                check("held_dest", 128'(ctl_mem0_dest_o), 128'(m_dest(cur)));
                check("held_fwd", 128'(forward_mem0_data_o), 128'(cur.exe));
                check("held_pc", 128'(ctl_mem0_pc_o), 128'(cur.pc));
            end
            if (data_req_o) begin
                if (pending)
                    check("req_stable", 128'({data_wr_o, data_size_o, data_addr_o, data_wstrb_o,
                                              data_wdata_o}), 128'(saved_req));
                if (data_addr_ok_i) begin
                    check("req_orphan", 128'(inst_q.size() != 0), 128'd1);
                    if (inst_q.size() != 0) begin
                        cur = inst_q[0];
                        check("req_dup", 128'(front_req_done), 128'd0);
                        check("req_needed", 128'(needs_req(cur)), 128'd1);
                        check("req_wr", 128'(data_wr_o), 128'(cur.ctl[4]));
                        check("req_size", 128'(data_size_o), 128'(cur.ctl[3:2]));
                        check("req_addr", 128'(data_addr_o), 128'(cur.exe));
                        check("req_wstrb", 128'(data_wstrb_o), 128'(m_wstrb(cur)));
                        if (cur.ctl[4]) check("req_wdata", 128'(data_wdata_o), 128'(m_wdata(cur)));
                        front_req_done = 1'b1;
                    end
                    pending = 1'b0;
                end else begin
                    pending   = 1'b1;
                    saved_req = {data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o};
                end
            end else if (pending) begin
                check("req_withdrawn", 128'(data_req_o), 128'd1);
                pending = 1'b0;
            end
            if (mem02mem1_valid_o && mem1_allow_in_i) begin
                check("mem1_spurious", 128'(inst_q.size() != 0), 128'd1);
                if (inst_q.size() != 0) begin
                    cur = inst_q.pop_front();
                    check("mem1_bus", 128'(mem02mem1_bus_o), 128'(m_bus(cur)));
                    check("req_issued", 128'(front_req_done), 128'(needs_req(cur)));
                    front_req_done = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        instr_t nop;
        instr_t ins;
        int     guard;
        nop             = '0;
        rst_i           = 1'b1;
        ex2mem0_valid_i = 1'b0;
        ex2mem0_bus_i   = '0;
        mem1_allow_in_i = 1'b0;
        data_addr_ok_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_allow", 128'(mem0_allow_in_o), 128'd1);
        check("rst_req", 128'(data_req_o), 128'd0);
        check("rst_valid", 128'(mem02mem1_valid_o), 128'd0);
        check("rst_bus", 128'(mem02mem1_bus_o), 128'd0);
        check("rst_wstrb", 128'(data_wstrb_o), 128'd0);
        check("rst_misc", 128'({ctl_mem0_dest_o, forward_mem0_data_o, ctl_mem0_pc_o,
                                data_addr_o, data_wdata_o}), 128'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);

        // ALU op: valid the cycle after accept, no request
        cycle(1'b1, mk(6'h00, 32'h0, 32'h1234, 5'd3, 1'b1, 32'h100), 1'b1, 1'b0);
        cycle(1'b0, nop, 1'b1, 1'b0);
        check("alu_valid", 128'(mem02mem1_valid_o), 128'd1);
        check("alu_noreq", 128'(data_req_o), 128'd0);
        check("alu_dest", 128'(ctl_mem0_dest_o), 128'd3);

        // store byte, ack on third request cycle
        cycle(1'b1, mk(6'b010000, 32'hAB, 32'h1003, 5'd4, 1'b0, 32'h104), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, nop, 1'b1, (k == 2));
            check("sb_req", 128'(data_req_o), 128'd1);
            check("sb_wstrb", 128'(data_wstrb_o), 128'h8);
            check("sb_wdata", 128'(data_wdata_o), 128'hABAB_ABAB);
            check("sb_allow", 128'(mem0_allow_in_o), 128'd0);
        end
        cycle(1'b0, nop, 1'b1, 1'b0);
        check("sb_done", 128'({data_req_o, mem02mem1_valid_o}), 128'b01);

        // load half unsigned, immediate ack, then MEM1 stalls 4 cycles
        cycle(1'b1, mk(6'b100110, 32'h0, 32'h2002, 5'd7, 1'b1, 32'h108), 1'b1, 1'b0);
        cycle(1'b0, nop, 1'b0, 1'b1);
        check("lh_size", 128'(data_size_o), 128'd1);
        check("lh_wstrb", 128'(data_wstrb_o), 128'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, rand_instr(), 1'b0, 1'b1);
            check("lh_valid", 128'(mem02mem1_valid_o), 128'd1);
            check("lh_addr_lo", 128'(mem02mem1_bus_o[71:70]), 128'd2);
            check("lh_allow", 128'(mem0_allow_in_o), 128'd0);
        end
        cycle(1'b0, nop, 1'b1, 1'b0);

        // back-to-back stores with immediate ack
        for (int k = 0; k < 4; k++)
            cycle(1'b1, mk(6'b011000, 32'h1111_0000 + k, 32'h40 + 4 * k, 5'd1, 1'b0, k), 1'b1,
                  1'b1);
        cycle(1'b0, nop, 1'b1, 1'b1);
        cycle(1'b0, nop, 1'b1, 1'b1);

`ifdef MEM0_ALIGN_CHECK_EN
        cycle(1'b1, mk(6'b101000, 32'h0, 32'h3001, 5'd9, 1'b1, 32'h10c), 1'b1, 1'b0);
        cycle(1'b0, nop, 1'b1, 1'b0);
        check("ale_noreq", 128'(data_req_o), 128'd0);
        check("ale_bit", 128'(mem02mem1_bus_o[78]), 128'd1);
        check("ale_we", 128'(mem02mem1_bus_o[32]), 128'd0);
        cycle(1'b0, nop, 1'b1, 1'b0);
`endif

        // reset while a request is outstanding
        cycle(1'b1, mk(6'b011000, 32'h5, 32'h80, 5'd2, 1'b0, 32'h110), 1'b1, 1'b0);
        cycle(1'b0, nop, 1'b1, 1'b0);
        check("rreq_req", 128'(data_req_o), 128'd1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        acc_pend = 1'b0;
        @(negedge clk_i);
        check("rreq_after", 128'({data_req_o, mem02mem1_valid_o, mem0_allow_in_o}), 128'b001);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ins = rand_instr();
            cycle(1'($urandom_range(0, 1)), ins, ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
        end

        guard = 0;
        while ((inst_q.size() != 0 || acc_pend) && guard < 100) begin
            cycle(1'b0, nop, 1'b1, 1'b1);
            guard++;
        end
        check("drain_empty", 128'(inst_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mem0_stage.md
Name: mem0_stage

Overview:
- First memory pipeline stage. Consumes the EX→MEM0 bus, latches it into a stage register and issues one data-memory address request per load/store through a req/addr_ok handshake.
- Forwards a MEM0→MEM1 bus to the second memory stage, which receives the load data.
- Also drives the destination register and forwarding data used by ID hazard logic.

Parameters:
- ADDR_W, 32, data address / register width.
- RD_W, 5, register address width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- ex2mem0_bus_i  input  108  {mem_ctl[5:0], st_data[31:0], exe_result[31:0], rd_addr[4:0], rd_we, pc[31:0]}, MSB first.
- ex2mem0_valid_i  input  1  EX holds a completed instruction.
- mem0_allow_in_o  output  1  MEM0 accepts a new instruction this cycle.
- mem02mem1_bus_o  output  78  {mem_ctl[5:0], addr_lo[1:0], exe_result[31:0], rd_addr[4:0], rd_we, pc[31:0]}.
- mem02mem1_valid_o  output  1  MEM0 holds a finished instruction.
- mem1_allow_in_i  input  1  MEM1 accepts this cycle.
- data_req_o  output  1  memory request valid.
- data_wr_o  output  1  1 = store, 0 = load.
- data_size_o  output  2  00 byte, 01 half, 10 word.
- data_addr_o  output  32  byte address (= exe_result).
- data_wstrb_o  output  4  byte write strobes; 0000 for loads.
- data_wdata_o  output  32  store data, replicated per size.
- data_addr_ok_i  input  1  memory accepted the request.
- ctl_mem0_dest_o  output  5  rd_addr when the stage is valid and rd_we=1, else 0.
- forward_mem0_data_o  output  32  exe_result of the held instruction.
- ctl_mem0_pc_o  output  32  pc of the held instruction.

Behaviour:
mem_ctl encoding:
- [5] load, [4] store, [3:2] size, [1] unsigned-load, [0] reserved (passed through).
- A memory op is load | store; both set never occurs.

Reset:
- valid_r=0, state=IDLE, stage register=0.
- All outputs 0 except mem0_allow_in_o=1.

States:
- IDLE: stage empty.
- REQ: memory op held, data_req_o=1.
- DONE: instruction complete, waiting for MEM1.

Acceptance and allow-in:
- Accept occurs when ex2mem0_valid_i & mem0_allow_in_o; the bus is latched and valid_r is set next cycle.
- mem0_allow_in_o = ~valid_r | (over & mem1_allow_in_i), where over = state==DONE.

State transitions after accept:
- Memory op → REQ.
- Non-memory op → DONE; zero-cycle residency beyond the register stage.

REQ state:
- data_req_o held high with stable addr/size/wstrb/wdata until the cycle data_addr_ok_i=1.
- Next state DONE. The request must never be withdrawn while unacknowledged.
- One-cycle minimum: addr_ok in the first REQ cycle gives DONE on the next edge.

DONE state:
- mem02mem1_valid_o=1.
- If mem1_allow_in_i: go to REQ/DONE when a new instruction is accepted the same edge, else IDLE.
- Otherwise hold.

Other boundary cases:
- data_addr_ok_i outside REQ is ignored.
- Reset in REQ drops data_req_o on the next edge; an outstanding accepted request is the memory side's concern.

Store data and strobes (a = addr[1:0]):
- byte: wstrb = 0001<<a, wdata = {4{st[7:0]}}.
- half: wstrb = 0011<<a, wdata = {2{st[15:0]}}.
- word: wstrb = 1111, wdata = st.

Other outputs:
- addr_lo in the MEM1 bus = exe_result[1:0].
- ctl_mem0_dest_o and forward_mem0_data_o are valid in every state with valid_r=1; 0 when empty.

Optional Feature:
MEM0_ALIGN_CHECK_EN.
- Defined: half with a[0]=1, or word with a≠0, is misaligned.
  - data_req_o is never raised and the instruction goes straight to DONE.
  - The MEM1 bus widens to 79 bits with an extra MSB ale=1.
  - rd_we is forced to 0 in the MEM1 bus and ctl_mem0_dest_o.
- Undefined: no check; the address is issued as-is and the bus is 78 bits.

Test Plan:
- ALU op (mem_ctl=0, exe_result=0x1234, rd=3, we=1), mem1_allow_in=1 → mem02mem1_valid_o=1 the cycle after accept, data_req_o never 1, ctl_mem0_dest_o=3.
- Store byte, addr=0x1003, st_data=0xAB, addr_ok delayed 3 cycles → data_req_o high 3 cycles with wstrb=1000, wdata=0xABABABAB stable; DONE after ack; mem0_allow_in_o=0 throughout.
- Load half unsigned, addr=0x2002, addr_ok same cycle as first REQ cycle → data_size_o=01, wstrb=0000, addr_lo=2 in the MEM1 bus, valid the next cycle.
- Back-to-back stores with mem1_allow_in=1 and immediate addr_ok → second accepted on the DONE→release edge, no bubble beyond the REQ cycle, no dropped or duplicated request.
- mem1_allow_in=0 for 4 cycles in DONE → outputs stable, allow_in=0; rst_i pulsed while in REQ → data_req_o=0, valid=0, allow_in=1 the next cycle.
- With MEM0_ALIGN_CHECK_EN: word load at 0x3001 → no data_req_o, ale=1, rd_we=0 in the MEM1 bus.
